// File: rtl/fetch_redirect_unit.sv
// PC register and IF/ID, ID/EX valid tracker; applies jump/branch redirects and squashes.
// Optional redirect/squash/stall counters are enabled by defining FETCH_STATS_EN.
module fetch_redirect_unit #(
   parameter int unsigned      PC_W     = 32,
   parameter logic [PC_W-1:0]  RESET_PC = 32'h0000_0000
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_stall,
   input  logic [1:0]      i_pc_src,
   input  logic            i_kill1,
   input  logic            i_kill2,
   input  logic [PC_W-1:0] i_jump_target,
   input  logic [PC_W-1:0] i_branch_target,
   output logic [PC_W-1:0] o_pc,
   output logic [PC_W-1:0] o_pc_plus4,
   output logic            o_ifid_we,
   output logic            o_ifid_valid,
   output logic            o_idex_valid,
   output logic            o_redirect,
`ifdef FETCH_STATS_EN
   output logic [31:0]     o_redirect_cnt,
   output logic [31:0]     o_squash_cnt,
   output logic [31:0]     o_stall_cnt,
`endif
   output logic            o_proto_err
);

   logic [PC_W-1:0] r_pc;
   logic            r_ifid_valid;
   logic            r_idex_valid;
   logic            r_redirect;
   logic            r_proto_err;

   logic            w_br_acc;
   logic            w_j_acc;
   logic            w_kill_err;
   logic [PC_W-1:0] w_pc_plus4;
   logic [PC_W-1:0] w_pc_next;
   logic            w_ifid_valid_next;
   logic            w_idex_valid_next;

   assign w_pc_plus4 = r_pc + PC_W'(4);

   // Redirect acceptance is gated by the stage that owns the request being live.
   assign w_br_acc = i_pc_src[1] & r_idex_valid;
   assign w_j_acc  = (i_pc_src == 2'b01) & r_ifid_valid & ~i_stall;

   // Kill lines are checked only against stages holding live instructions.
   assign w_kill_err = (r_ifid_valid & (i_kill1 != (|i_pc_src)))
                     | (r_idex_valid & (i_kill2 != i_pc_src[1]));

   always_comb begin
      w_pc_next         = w_pc_plus4;
      w_ifid_valid_next = 1'b1;
      w_idex_valid_next = r_ifid_valid;
      if (w_br_acc) begin
         w_pc_next         = {i_branch_target[PC_W-1:2], 2'b00};
         w_ifid_valid_next = 1'b0;
         w_idex_valid_next = 1'b0;
      end else if (w_j_acc) begin
         w_pc_next         = {i_jump_target[PC_W-1:2], 2'b00};
         w_ifid_valid_next = 1'b0;
      end else if (i_stall) begin
         w_pc_next         = r_pc;
         w_ifid_valid_next = r_ifid_valid;
         w_idex_valid_next = 1'b0;
      end else begin
         w_pc_next         = w_pc_plus4;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pc         <= RESET_PC;
         r_ifid_valid <= 1'b0;
         r_idex_valid <= 1'b0;
         r_redirect   <= 1'b0;
         r_proto_err  <= 1'b0;
      end else begin
         r_pc         <= w_pc_next;
         r_ifid_valid <= w_ifid_valid_next;
         r_idex_valid <= w_idex_valid_next;
         r_redirect   <= w_br_acc | w_j_acc;
         r_proto_err  <= r_proto_err | w_kill_err;
      end
   end

`ifdef FETCH_STATS_EN
   logic [31:0] r_redirect_cnt;
   logic [31:0] r_squash_cnt;
   logic [31:0] r_stall_cnt;
   logic [31:0] w_squash_inc;

   // A branch kills whatever is live in both IF/ID and ID/EX; a jump kills IF/ID only.
   always_comb begin
      w_squash_inc = 32'd0;
      if (w_br_acc) begin
         w_squash_inc = 32'(r_ifid_valid) + 32'(r_idex_valid);
      end else if (w_j_acc) begin
         w_squash_inc = 32'(r_ifid_valid);
      end else begin
         w_squash_inc = 32'd0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_redirect_cnt <= 32'd0;
         r_squash_cnt   <= 32'd0;
         r_stall_cnt    <= 32'd0;
      end else begin
         r_redirect_cnt <= r_redirect_cnt + 32'(w_br_acc | w_j_acc);
         r_squash_cnt   <= r_squash_cnt + w_squash_inc;
         r_stall_cnt    <= r_stall_cnt + 32'(i_stall & ~w_br_acc);
      end
   end

   assign o_redirect_cnt = r_redirect_cnt;
   assign o_squash_cnt   = r_squash_cnt;
   assign o_stall_cnt    = r_stall_cnt;
`endif

   assign o_pc         = r_pc;
   assign o_pc_plus4   = w_pc_plus4;
   assign o_ifid_we    = ~i_rst & (~i_stall | w_br_acc);
   assign o_ifid_valid = r_ifid_valid;
   assign o_idex_valid = r_idex_valid;
   assign o_redirect   = r_redirect;
   assign o_proto_err  = r_proto_err;

endmodule
